seg_dyn_scan: RTL and testbench



---
 rtl/seg_dyn_scan.sv | 135 +++++++++++++
 tb/tb_seg_dyn_scan.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_dyn_scan.sv
// Six-digit multiplexed seven-segment scan driver for a common-anode display.
// Define SEG_LZ_BLANK_EN to enable leading-zero blanking.
module seg_dyn_scan #(
    parameter logic [15:0] CNT_MAX = 16'd49_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [3:0] unit,
    input  logic [3:0] ten,
    input  logic [3:0] hun,
    input  logic [3:0] tho,
    input  logic [3:0] t_tho,
    input  logic [3:0] h_hun,
    input  logic [5:0] point,
    input  logic       seg_en,
    output logic [5:0] sel,
    output logic [7:0] seg
);

    logic [15:0]     cnt_1ms;
    logic            flag_1ms;
    logic [2:0]      cnt_sel;
    logic [5:0][3:0] sh_dig;
    logic [5:0]      sh_point;

    logic [3:0] sel_digit;
    logic       sel_dp;
    logic       sel_blank;

    logic [3:0] s1_digit;
    logic       s1_dp;
    logic       s1_blank;
    logic       s1_en;
    logic [2:0] s1_idx;

    logic [6:0] seg_dec;
    logic [5:0] sel_dec;
    logic [5:0] sel_d;
    logic [7:0] seg_d;

    assign flag_1ms = (cnt_1ms == CNT_MAX);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_1ms <= '0;
            cnt_sel <= '0;
        end else if (flag_1ms) begin
            cnt_1ms <= '0;
            cnt_sel <= (cnt_sel == 3'd5) ? 3'd0 : cnt_sel + 3'd1;
        end else begin
            cnt_1ms <= cnt_1ms + 16'd1;
        end
    end

    // Snapshot at end of frame so a frame never mixes old and new digit values
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sh_dig   <= '0;
            sh_point <= '0;
        end else if (flag_1ms && cnt_sel == 3'd5) begin
            sh_dig   <= {h_hun, t_tho, tho, hun, ten, unit};
            sh_point <= point;
        end
    end

    always_comb begin
        sel_digit = sh_dig[0];
        sel_dp    = sh_point[0];
        sel_blank = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (cnt_sel == 3'(i)) begin
                sel_digit = sh_dig[i];
                sel_dp    = sh_point[i];
`ifdef SEG_LZ_BLANK_EN
                // Blank only if this digit and everything above it is zero with no dp
                sel_blank = (i != 0);
                for (int j = i; j < 6; j++) begin
                    if (sh_dig[j] != 4'd0 || sh_point[j]) sel_blank = 1'b0;
                end
`endif
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1_digit <= '0;
            s1_dp    <= 1'b0;
            s1_blank <= 1'b0;
            s1_en    <= 1'b0;
            s1_idx   <= '0;
        end else begin
            s1_digit <= sel_digit;
            s1_dp    <= sel_dp;
            s1_blank <= sel_blank;
            s1_en    <= seg_en;
            s1_idx   <= cnt_sel;
        end
    end

    always_comb begin
        case (s1_digit)
            4'd0:    seg_dec = 7'h40;
            4'd1:    seg_dec = 7'h79;
            4'd2:    seg_dec = 7'h24;
            4'd3:    seg_dec = 7'h30;
            4'd4:    seg_dec = 7'h19;
            4'd5:    seg_dec = 7'h12;
            4'd6:    seg_dec = 7'h02;
            4'd7:    seg_dec = 7'h78;
            4'd8:    seg_dec = 7'h00;
            4'd9:    seg_dec = 7'h10;
            default: seg_dec = 7'h7F;
        endcase
        sel_dec = ~(6'b000001 << s1_idx);
        sel_d   = 6'h3F;
        seg_d   = 8'hFF;
        if (s1_en) begin
            sel_d = sel_dec;
            if (!s1_blank) seg_d = {~s1_dp, seg_dec};
        end
    end

    // sel and seg share one register stage so they always switch together
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sel <= 6'h3F;
            seg <= 8'hFF;
        end else begin
            sel <= sel_d;
            seg <= seg_d;
        end
    end

endmodule

// File: tb/tb_seg_dyn_scan.sv
// Self-checking bench for seg_dyn_scan: per-cycle reference model plus directed frame checks.
`timescale 1ns/1ps
module tb_seg_dyn_scan;

    localparam logic [15:0] CNT_MAX = 16'd9;
    localparam logic [13:0] OFF     = 14'h3FFF;
    localparam logic [7:0]  SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                             8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
`ifdef SEG_LZ_BLANK_EN
    localparam logic [7:0] BZ = 8'hFF;
`else
    localparam logic [7:0] BZ = 8'hC0;
`endif

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [3:0] dig [6];
    logic [5:0] point;
    logic       seg_en;
    logic [5:0] sel;
    logic [7:0] seg;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int          m_cnt;
    int          m_idx;
    logic [3:0]  m_sh [6];
    logic [5:0]  m_pt;
    logic [13:0] pend;
    logic [13:0] exp_out;

    seg_dyn_scan #(.CNT_MAX(CNT_MAX)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .unit      (dig[0]),
        .ten       (dig[1]),
        .hun       (dig[2]),
        .tho       (dig[3]),
        .t_tho     (dig[4]),
        .h_hun     (dig[5]),
        .point     (point),
        .seg_en    (seg_en),
        .sel       (sel),
        .seg       (seg)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Ideal {sel, seg} for a given digit slot, straight from the display rules
    function automatic logic [13:0] ideal(input int idx, input logic en);
        logic [6:0] low;
        logic       blank;
        logic [5:0] s;
        if (!en) return OFF;
        blank = 1'b0;
`ifdef SEG_LZ_BLANK_EN
        if (idx != 0) begin
            blank = 1'b1;
            for (int j = idx; j < 6; j++)
                if (m_sh[j] != 0 || m_pt[j]) blank = 1'b0;
        end
`endif
        s = ~(6'b000001 << idx);
        if (blank) return {s, 8'hFF};
        low = (m_sh[idx] <= 9) ? SEG_TAB[m_sh[idx]][6:0] : 7'h7F;
        return {s, ~m_pt[idx], low};
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        m_idx = 0;
        for (int i = 0; i < 6; i++) m_sh[i] = 4'd0;
        m_pt = 6'd0;
        pend = OFF;
    endtask

    task automatic model_step();
        if (m_cnt == int'(CNT_MAX)) begin
            if (m_idx == 5) begin
                m_sh = dig;
                m_pt = point;
            end
            m_idx = (m_idx + 1) % 6;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    // Output after an edge equals the ideal value of the state seen one edge earlier
    always @(posedge sys_clk) begin
        #1;
        if (!sys_rst_n) begin
            model_reset();
            exp_out = OFF;
        end else begin
            exp_out = pend;
            pend    = ideal(m_idx, seg_en);
            model_step();
        end
        check("scan", {2'b00, sel, seg}, {2'b00, exp_out});
    end

    task automatic wait_sel(input logic [5:0] target, input int budget, input string tag);
        int n;
        n = 0;
        while (sel == target && n < budget) begin @(posedge sys_clk); #2; n++; end
        while (sel != target && n < budget) begin @(posedge sys_clk); #2; n++; end
        if (sel != target) check({tag, "_timeout"}, {10'd0, sel}, {10'd0, target});
    endtask

    task automatic set_digits(input logic [3:0] d5, d4, d3, d2, d1, d0, input logic [5:0] pt);
        @(negedge sys_clk);
        dig[5] = d5; dig[4] = d4; dig[3] = d3;
        dig[2] = d2; dig[1] = d1; dig[0] = d0;
        point  = pt;
    endtask

    task automatic check_frame(input string tag, input logic [7:0] e0, e1, e2, e3, e4, e5);
        logic [7:0] e [6];
        logic [5:0] t;
        e = '{e0, e1, e2, e3, e4, e5};
        // Two digit-0 entries guarantee a snapshot after the input change
        wait_sel(6'b111110, 200, tag);
        wait_sel(6'b111110, 200, tag);
        for (int k = 0; k < 6; k++) begin
            t = ~(6'b000001 << k);
            if (k != 0) wait_sel(t, 15, tag);
            check($sformatf("%s_d%0d", tag, k), {8'd0, seg}, {8'd0, e[k]});
        end
    endtask

    initial begin
        seg_en = 1'b1;
        point  = 6'd0;
        for (int i = 0; i < 6; i++) dig[i] = 4'd0;
        sys_rst_n = 1'b0;
        repeat (5) @(posedge sys_clk);
        #2 check("reset", {2'b00, sel, seg}, {2'b00, OFF});
        @(negedge sys_clk) sys_rst_n = 1'b1;
        wait_sel(6'b111110, 10, "first");
        check("first_seg", {8'd0, seg}, {8'd0, 8'hC0});

        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 6'd0);
        check_frame("count", 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9);

        // Change unit while digit 3 is on screen
        wait_sel(6'b110111, 80, "mid");
        @(negedge sys_clk) dig[0] = 4'd9;
        wait_sel(6'b101111, 15, "mid");
        check("mid_d4", {8'd0, seg}, {8'd0, 8'hA4});
        wait_sel(6'b011111, 15, "mid");
        check("mid_d5", {8'd0, seg}, {8'd0, 8'hF9});
        wait_sel(6'b111110, 15, "mid");
        check("mid_d0", {8'd0, seg}, {8'd0, 8'h90});

        set_digits(4'd0, 4'd0, 4'd1, 4'd4, 4'd3, 4'd2, 6'b000100);
        check_frame("dp", 8'hA4, 8'hB0, 8'h19, 8'hF9, BZ, BZ);

        set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd2, 6'd0);
        check_frame("lz", 8'hA4, 8'h99, BZ, BZ, BZ, BZ);
        set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd2, 6'b000100);
        check_frame("lz_dp", 8'hA4, 8'h99, 8'h40, BZ, BZ, BZ);

        set_digits(4'd12, 4'd0, 4'd0, 4'd0, 4'd0, 4'd15, 6'b000001);
        check_frame("bad", 8'h7F, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hFF);

        // Blank the display mid-slot
        wait_sel(6'b111011, 80, "en");
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk) seg_en = 1'b0;
        @(posedge sys_clk); #2;
        @(posedge sys_clk); #2;
        check("en_off", {2'b00, sel, seg}, {2'b00, OFF});
        repeat (28) @(negedge sys_clk);
        seg_en = 1'b1;
        repeat (20) @(posedge sys_clk);

        // Asynchronous reset mid-scan
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1 check("async_rst", {2'b00, sel, seg}, {2'b00, OFF});
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        wait_sel(6'b111110, 10, "rst_first");
        check("rst_first_seg", {8'd0, seg}, {8'd0, 8'hC0});

        for (int c = 0; c < 3000; c++) begin
            @(negedge sys_clk);
            sys_rst_n = ($urandom_range(0, 999) != 0);
            if ($urandom_range(0, 19) == 0) dig[$urandom_range(0, 5)] = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) point = 6'($urandom);
            if ($urandom_range(0, 59) == 0) seg_en = ~seg_en;
            if ($urandom_range(0, 199) == 0)
                for (int i = 0; i < 6; i++) dig[i] = ($urandom_range(0, 1) == 0) ? 4'd0 : dig[i];
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        seg_en = 1'b1;
        repeat (5) @(posedge sys_clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
